// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: credit-limited imem requests, in-order
// response FIFO toward decode, redirect flush with stale-response discard.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];

  logic [31:0]     fetch_pc;
  logic [31:0]     fetch_pc_n;
  logic [31:0]     rsp_pc;
  logic [31:0]     rsp_pc_n;
  logic [31:0]     target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_n;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   discard_n;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   wr_ptr_n;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_n;
  logic [CW:0]     in_use;
  logic            credit;
  logic            accept;
  logic            rsp;
  logic            drop;
  logic            push;
  logic            pop;
  logic            unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];
  assign target     = {redirect_pc[31:2], 2'b00};

  assign in_use   = {1'b0, outstanding} + {1'b0, count};
  assign credit   = in_use < LIMIT;
  assign imem_req = rst_n && !redirect && credit;
  assign imem_addr = fetch_pc;

  assign accept = imem_req && imem_gnt;
  // responses with nothing outstanding are protocol noise
  assign rsp  = imem_rvalid && (outstanding != '0);
  assign drop = rsp && (redirect || (discard != '0));
  assign push = rsp && !drop;
  assign pop  = instr_valid && instr_ready && !redirect;

  assign instr_valid = count != '0;
  assign instr    = instr_valid ? mem[rd_ptr].word : NOP;
  assign instr_pc = instr_valid ? mem[rd_ptr].pc : rsp_pc;

  always_comb begin
    outstanding_n = outstanding
                  + CW'(accept)
                  - CW'(rsp);
    fetch_pc_n = fetch_pc;
    rsp_pc_n   = rsp_pc;
    count_n    = count;
    discard_n  = discard;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    if (redirect) begin
      // everything still in flight belongs to the old path
      fetch_pc_n = target;
      rsp_pc_n   = target;
      count_n    = '0;
      discard_n  = outstanding_n;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
    end else begin
      if (accept) fetch_pc_n = fetch_pc + 32'd4;
      if (push) begin
        rsp_pc_n = rsp_pc + 32'd4;
        wr_ptr_n = wr_ptr + AW'(1);
      end
      if (pop) rd_ptr_n = rd_ptr + AW'(1);
      if (drop) discard_n = discard - CW'(1);
      unique case ({push, pop})
        2'b10:   count_n = count + CW'(1);
        2'b01:   count_n = count - CW'(1);
        default: count_n = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      rsp_pc      <= rsp_pc_n;
      outstanding <= outstanding_n;
      count       <= count_n;
      discard     <= discard_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{word: imem_rdata, pc: rsp_pc};
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: streaming, stall, redirect,
// grant backpressure, PC wrap and asynchronous reset.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic g, input logic v,
                     input logic [31:0] d, input logic r,
                     input logic rd, input logic [31:0] rp);
    imem_gnt    = g;
    imem_rvalid = v;
    imem_rdata  = d;
    instr_ready = r;
    redirect    = rd;
    redirect_pc = rp;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    rst_n = 1'b1;

    // streaming, ready held high
    drv(1, 0, 0, 1, 0, 0);
    chk("s1_req0", imem_req, 1);
    chk("s1_addr0", imem_addr, 32'h0);
    tick();
    drv(1, 1, dat(32'h0), 1, 0, 0);
    chk("s1_addr4", imem_addr, 32'h4);
    chk("s1_valid_early", instr_valid, 0);
    tick();
    drv(1, 1, dat(32'h4), 1, 0, 0);
    chk("s1_first_valid", instr_valid, 1);
    chk("s1_instr0", instr, dat(32'h0));
    chk("s1_pc0", instr_pc, 32'h0);
    chk("s1_credit", imem_req, 0);
    tick();
    drv(1, 0, 0, 1, 0, 0);
    chk("s1_pc4", instr_pc, 32'h4);
    chk("s1_instr4", instr, dat(32'h4));
    chk("s1_addr8", imem_addr, 32'h8);
    chk("s1_req8", imem_req, 1);
    tick();
    drv(1, 1, dat(32'h8), 1, 0, 0);
    chk("s1_empty", instr_valid, 0);
    chk("s1_addrc", imem_addr, 32'hC);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    chk("s1_pc8", instr_pc, 32'h8);
    chk("s1_instr8", instr, dat(32'h8));
    tick();

    // full stall with ready low
    do_reset();
    drv(1, 0, 0, 0, 0, 0);
    chk("s2_addr0", imem_addr, 32'h0);
    tick();
    drv(1, 1, dat(32'h0), 0, 0, 0);
    chk("s2_addr4", imem_addr, 32'h4);
    tick();
    drv(1, 1, dat(32'h4), 0, 0, 0);
    chk("s2_req_off", imem_req, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0);
    chk("s2_full_stall", imem_req, 0);
    chk("s2_valid", instr_valid, 1);
    chk("s2_pc0", instr_pc, 32'h0);
    tick();
    drv(1, 0, 0, 1, 0, 0);
    chk("s2_pop_req", imem_req, 0);
    chk("s2_pop_instr", instr, dat(32'h0));
    tick();
    drv(1, 0, 0, 0, 0, 0);
    chk("s2_req8", imem_req, 1);
    chk("s2_addr8", imem_addr, 32'h8);
    chk("s2_pc4", instr_pc, 32'h4);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("s2_restall", imem_req, 0);
    tick();

    // redirect with two stale requests
    do_reset();
    drv(0, 0, 0, 0, 1, 32'h10);
    chk("s3_redir_req", imem_req, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0);
    chk("s3_addr10", imem_addr, 32'h10);
    tick();
    drv(1, 0, 0, 0, 0, 0);
    chk("s3_addr14", imem_addr, 32'h14);
    tick();
    drv(1, 0, 0, 0, 1, 32'h103);
    chk("s3_redir_req2", imem_req, 0);
    tick();
    drv(1, 1, dat(32'h10), 0, 0, 0);
    chk("s3_credit", imem_req, 0);
    tick();
    drv(1, 1, dat(32'h14), 0, 0, 0);
    chk("s3_req100", imem_req, 1);
    chk("s3_addr100", imem_addr, 32'h100);
    chk("s3_drop1", instr_valid, 0);
    tick();
    drv(0, 1, dat(32'h100), 0, 0, 0);
    chk("s3_drop2", instr_valid, 0);
    chk("s3_addr104", imem_addr, 32'h104);
    tick();
    drv(1, 0, 0, 0, 0, 0);
    chk("s3_valid", instr_valid, 1);
    chk("s3_pc100", instr_pc, 32'h100);
    chk("s3_instr100", instr, dat(32'h100));
    tick();

    // redirect with rvalid and pop in the same cycle
    drv(1, 1, dat(32'h104), 1, 1, 32'h200);
    chk("s4_req", imem_req, 0);
    tick();
    drv(1, 0, 0, 1, 0, 0);
    chk("s4_flush", instr_valid, 0);
    chk("s4_nop", instr, NOP);
    chk("s4_addr200", imem_addr, 32'h200);
    tick();
    drv(0, 1, dat(32'h200), 1, 0, 0);
    chk("s4_addr204", imem_addr, 32'h204);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    chk("s4_valid", instr_valid, 1);
    chk("s4_pc200", instr_pc, 32'h200);
    chk("s4_instr200", instr, dat(32'h200));
    tick();

    // grant withheld three cycles at 0x8
    do_reset();
    drv(1, 0, 0, 1, 0, 0);
    tick();
    drv(1, 1, dat(32'h0), 1, 0, 0);
    tick();
    drv(0, 1, dat(32'h4), 1, 0, 0);
    chk("s5_credit", imem_req, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 1, 0, 0);
      chk("s5_hold_req", imem_req, 1);
      chk("s5_hold_addr", imem_addr, 32'h8);
      tick();
    end
    drv(1, 0, 0, 1, 0, 0);
    chk("s5_gnt_addr", imem_addr, 32'h8);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    chk("s5_addrc", imem_addr, 32'hC);
    tick();

    // PC wrap then asynchronous reset mid-stream
    do_reset();
    drv(0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    tick();
    drv(1, 0, 0, 0, 0, 0);
    chk("s6_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    drv(1, 1, dat(32'hFFFF_FFFC), 0, 0, 0);
    chk("s6_wrap", imem_addr, 32'h0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("s6_valid", instr_valid, 1);
    chk("s6_pc_top", instr_pc, 32'hFFFF_FFFC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_arst_valid", instr_valid, 0);
    chk("s6_arst_req", imem_req, 0);
    chk("s6_arst_instr", instr, NOP);
    chk("s6_arst_pc", instr_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(0, 1, dat(32'h4), 0, 0, 0);
    chk("s6_restart_req", imem_req, 1);
    chk("s6_restart_addr", imem_addr, 32'h0);
    tick();
    drv(1, 0, 0, 0, 0, 0);
    chk("s6_late_rsp", instr_valid, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("s6_addr4", imem_addr, 32'h4);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch unit feeding the RV32I instruction decoder. It drives instruction-memory requests from a fetch PC and buffers returned words in order in a small FIFO. It presents {instr, pc} to decode over a valid/ready handshake. It handles branch/jump redirects by flushing buffered words and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h00000000, fetch PC loaded on reset
DEPTH, 2, FIFO entries; also caps outstanding requests plus buffered words (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle (only meaningful when imem_req=1)
imem_rvalid  in  1  read data valid, responses in request order, >=1 cycle after gnt
imem_rdata  in  32  instruction word
instr_valid  out  1  FIFO head valid toward decode
instr  out  32  instruction to decoder
instr_pc  out  32  address of instr
instr_ready  in  1  decode consumes head this cycle
redirect  in  1  branch/jal/jalr taken, one-cycle pulse
redirect_pc  in  32  new fetch target

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC; FIFO count=0; outstanding=0; discard=0; imem_req=0; instr_valid=0; instr=32'h00000013 (NOP); instr_pc=RESET_PC.
- imem_addr = fetch_pc. fetch_pc[1:0] is always 2'b00; redirect_pc[1:0] is ignored and zeroed.
- Credit rule: imem_req = !redirect && (outstanding + count < DEPTH). imem_req is combinational from registered state and redirect.
- Accept (imem_req && imem_gnt): fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1. Address is held stable while imem_req=1 and gnt=0.
- Response (imem_rvalid): outstanding -= 1.
  - If discard>0: discard -= 1 and the word is dropped.
  - Else: push {imem_rdata, pc tag} into the FIFO. The pc tag comes from a per-request tag queue of DEPTH entries, or an equivalent response-PC counter.
- Latency: rvalid in cycle T -> instr_valid=1 in T+1 (registered FIFO write). With gnt the same cycle as the request and rvalid the next cycle, the first instruction appears 2 cycles after the request.
- Output: instr_valid = (count>0); instr/instr_pc = head. When empty, instr = 32'h00000013.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - FIFO cannot overflow under the credit rule. An rvalid with outstanding=0 is a protocol error and is ignored.
- Redirect (cycle N):
  - FIFO flushed: count=0, instr_valid=0 at N+1.
  - fetch_pc=redirect_pc at N+1.
  - discard = outstanding after this cycle's accounting, minus any response in cycle N that decremented it. That response is itself dropped.
  - imem_req=0 in cycle N. No request is issued in N, so no grant is counted.
  - Redirect has priority over pop, push and accept in the same cycle.
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
- New requests after a redirect may issue while discard>0, subject to the credit rule: outstanding includes stale requests.
- States (implicit in counters): IDLE_EMPTY, STREAMING, FULL_STALL (credit exhausted, imem_req=0), DRAINING (discard>0). No separate FSM register is required.
- Reset asserted mid-transaction: all counters clear immediately. Responses arriving after reset release with outstanding=0 are ignored.

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after gnt, ready=1 -> imem_addr 0x0,0x4,0x8...; instr_pc sequence 0x0,0x4,0x8 with matching rdata; first instr_valid 2 cycles after first req.
- ready=0 held, gnt=1, DEPTH=2 -> two words buffered, imem_req=0 (FULL_STALL); ready=1 one cycle -> pop 0x0, one new request to 0x8 issued.
- Two requests outstanding (0x10,0x14), redirect to 0x103 -> both responses dropped; next imem_addr=0x100; first instr_valid has instr_pc=0x100.
- Redirect in same cycle as rvalid and instr_ready&&valid -> FIFO empty next cycle, that response dropped, no extra pop, fetch_pc=redirect target.
- gnt withheld 3 cycles -> imem_req=1 and imem_addr stable at 0x8 throughout; fetch_pc advances only after gnt.
- fetch_pc=0xFFFFFFFC accepted -> next imem_addr=0x00000000; rst_n pulsed low mid-stream -> instr_valid=0, imem_req=0 immediately, restart at RESET_PC.
